// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keymap event decoder.
package ps2_pkg;

  // Set-2 prefix bytes
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // Scancode sequence decoder state
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  // Queued key event: rel=1 for break, key indexes the keymap
  typedef struct packed {
    logic       rel;
    logic [3:0] key;
  } key_event_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_EXT) || (b == SC_BRK);
  endfunction

  function automatic key_event_t make_event(input logic rel, input logic [3:0] key);
    key_event_t ev;
    ev.rel = rel;
    ev.key = key;
    return ev;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: line sync, clock glitch filter,
// 11-bit frame shifter with odd parity / stop check and mid-frame timeout.
module ps2_frame_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2clk,
  input  logic       i_ps2data,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FLT_LOAD = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYC - 1);

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_clk_filt;
  logic [FW-1:0] r_flt_cnt;
  logic          r_edge;
  logic          r_fall;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_to_cnt;

  logic w_clk_s;
  logic w_dat_s;

  assign w_clk_s = r_clk_sync[1];
  assign w_dat_s = r_dat_sync[1];

  // Two-flop synchronisers; both lines idle high
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2data};
    end
  end

  // Filtered clock follows the synced clock only after FILTER_LEN consecutive differing cycles
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_filt <= 1'b1;
      r_flt_cnt  <= FLT_LOAD;
      r_edge     <= 1'b0;
      r_fall     <= 1'b0;
    end else begin
      r_edge <= 1'b0;
      r_fall <= 1'b0;
      if (w_clk_s == r_clk_filt) begin
        r_flt_cnt <= FLT_LOAD;
      end else if (r_flt_cnt == '0) begin
        r_clk_filt <= w_clk_s;
        r_flt_cnt  <= FLT_LOAD;
        r_edge     <= 1'b1;
        r_fall     <= ~w_clk_s;
      end else begin
        r_flt_cnt <= r_flt_cnt - FW'(1);
      end
    end
  end

  // Frame shifter: bit count 0 waits for start, 1..8 data, 9 parity, 10 stop
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit_cnt    <= 4'd0;
      r_shift      <= 8'h00;
      r_parity     <= 1'b0;
      r_to_cnt     <= TO_LOAD;
      o_byte_valid <= 1'b0;
      o_byte       <= 8'h00;
      o_err        <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      o_err        <= 1'b0;

      if (r_edge) begin
        r_to_cnt <= TO_LOAD;
      end else if (r_bit_cnt != 4'd0) begin
        r_to_cnt <= r_to_cnt - TW'(1);
      end else begin
        r_to_cnt <= TO_LOAD;
      end

      if (r_fall) begin
        if (r_bit_cnt == 4'd0) begin
          // a high start bit is a stray edge, not a frame
          if (!w_dat_s) r_bit_cnt <= 4'd1;
        end else if (r_bit_cnt <= 4'd8) begin
          r_shift   <= {w_dat_s, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end else if (r_bit_cnt == 4'd9) begin
          r_parity  <= w_dat_s;
          r_bit_cnt <= 4'd10;
        end else begin
          r_bit_cnt <= 4'd0;
          if (w_dat_s && (^{r_shift, r_parity})) begin
            o_byte_valid <= 1'b1;
            o_byte       <= r_shift;
          end else begin
            o_err <= 1'b1;
          end
        end
      end else if (!r_edge && (r_bit_cnt != 4'd0) && (r_to_cnt == '0)) begin
        o_err     <= 1'b1;
        r_bit_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/ps2_keymap_event_decoder.sv
// PS/2 keyboard front end: set-2 make/break/extended decode, keymap lookup,
// held-key tracking and a small press/release event FIFO.
//
// Decoder states:
//   state      | meaning
//   ST_IDLE    | no prefix pending
//   ST_EXT     | E0 received, next code is extended make (or F0)
//   ST_BRK     | F0 received, next code is a normal break
//   ST_EXT_BRK | E0 F0 received, next code is an extended break
module ps2_keymap_event_decoder
  import ps2_pkg::*;
#(
  parameter int NUM_KEYS = 8,
  // entry 0 sits in bits [8:0]: Up, Down, Left, Right, R, Space, Esc, Enter
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES = {9'h05A, 9'h076, 9'h029, 9'h02D,
                                                9'h174, 9'h16B, 9'h172, 9'h175},
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 4,
  parameter int REPEAT_EN   = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_ps2clk,
  input  logic                i_ps2data,
  output logic [NUM_KEYS-1:0] o_key_held,
  output logic                o_ev_valid,
  input  logic                i_ev_ready,
  output logic                o_ev_release,
  output logic [3:0]          o_ev_key,
  output logic [7:0]          o_scancode,
  output logic                o_frame_err,
  output logic                o_overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic          REPEAT_ON = (REPEAT_EN != 0);

  logic       w_byte_valid;
  logic [7:0] w_byte;
  logic       w_rx_err;

  ps2_frame_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_ps2clk     (i_ps2clk),
    .i_ps2data    (i_ps2data),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte),
    .o_err        (w_rx_err)
  );

  dec_state_t          r_state;
  logic [7:0]          r_scancode;
  logic [NUM_KEYS-1:0] r_held;

  logic                w_code_byte;
  logic                w_ext;
  logic                w_brk;
  logic [NUM_KEYS-1:0] w_raw_hit;
  logic [NUM_KEYS-1:0] w_hit_oh;
  logic                w_hit;
  logic [3:0]          w_idx;
  logic                w_held_cur;
  logic                w_push;
  key_event_t          w_new_ev;

  // Qualify the received byte by the prefix context it arrives in
  always_comb begin
    w_code_byte = ~is_prefix(w_byte);
    w_ext       = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
    w_brk       = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_cmp
    assign w_raw_hit[g] = (KEY_CODES[g*9 +: 9] == {w_ext, w_byte});
  end

  // Lowest matching keymap index wins when the table holds duplicates
  always_comb begin
    w_hit_oh = '0;
    w_idx    = 4'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (w_raw_hit[i]) begin
        w_hit_oh    = '0;
        w_hit_oh[i] = 1'b1;
        w_idx       = 4'(i);
      end
    end
  end

  // A make of an already-held key is a typematic repeat
  always_comb begin
    w_hit      = |w_raw_hit;
    w_held_cur = |(w_hit_oh & r_held);
    w_push     = w_byte_valid & w_code_byte & w_hit &
                 (w_brk ? w_held_cur : (~w_held_cur | REPEAT_ON));
    w_new_ev   = make_event(w_brk, w_idx);
  end

  // Prefix sequencing; illegal prefix orders and frame errors fall back to idle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_scancode <= 8'h00;
    end else if (w_rx_err) begin
      r_state <= ST_IDLE;
    end else if (w_byte_valid) begin
      r_scancode <= w_byte;
      case (r_state)
        ST_IDLE: begin
          if (w_byte == SC_EXT)      r_state <= ST_EXT;
          else if (w_byte == SC_BRK) r_state <= ST_BRK;
          else                       r_state <= ST_IDLE;
        end
        ST_EXT: begin
          if (w_byte == SC_BRK) r_state <= ST_EXT_BRK;
          else                  r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Held map changes with every accepted event, even one the FIFO drops
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_held <= '0;
    end else if (w_push) begin
      r_held <= w_brk ? (r_held & ~w_hit_oh) : (r_held | w_hit_oh);
    end
  end

  key_event_t r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ev_valid;
  key_event_t    r_ev_head;
  logic          r_overflow;

  logic          w_pop;
  logic          w_full;
  logic          w_push_ok;
  logic [CW-1:0] w_remain;
  logic [CW-1:0] w_count_nxt;
  logic [AW-1:0] w_rd_ptr_nxt;
  key_event_t    w_head_nxt;

  // A pop in the same cycle frees the slot, so push-on-full with pop is not a drop
  always_comb begin
    w_pop        = r_ev_valid & i_ev_ready;
    w_full       = (r_count == FULL_CNT);
    w_push_ok    = w_push & (~w_full | w_pop);
    w_remain     = r_count - CW'(w_pop);
    w_count_nxt  = w_remain + CW'(w_push_ok);
    w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
    w_head_nxt   = (w_remain == '0) ? w_new_ev : r_mem[w_rd_ptr_nxt];
  end

  // FIFO pointers plus a registered copy of the next head entry
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ev_valid <= 1'b0;
      r_ev_head  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_ev_valid <= (w_count_nxt != '0);
      r_ev_head  <= w_head_nxt;
      if (w_push && !w_push_ok) r_overflow <= 1'b1;
    end
  end

  // Event storage needs no reset; validity is tracked by the count
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_new_ev;
  end

  assign o_key_held   = r_held;
  assign o_ev_valid   = r_ev_valid;
  assign o_ev_release = r_ev_head.rel;
  assign o_ev_key     = r_ev_head.key;
  assign o_scancode   = r_scancode;
  assign o_frame_err  = w_rx_err;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_keymap_event_decoder.sv
// Bench for ps2_keymap_event_decoder: bit-level PS/2 frames driven onto the
// pins, compared against a sequence-level keyboard model.
module tb_ps2_keymap_event_decoder;

  localparam int TO = 3000;

  logic       clk = 1'b0;
  logic       rst, ps2clk, ps2data, ev_ready;
  logic [7:0] key_held;
  logic       ev_valid, ev_release, frame_err, overflow;
  logic [3:0] ev_key;
  logic [7:0] scancode;

  always #5 clk = ~clk;

  ps2_keymap_event_decoder #(.TIMEOUT_CYC(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_ps2clk(ps2clk), .i_ps2data(ps2data),
    .o_key_held(key_held), .o_ev_valid(ev_valid), .i_ev_ready(ev_ready),
    .o_ev_release(ev_release), .o_ev_key(ev_key), .o_scancode(scancode),
    .o_frame_err(frame_err), .o_overflow(overflow)
  );

  int vectors = 0;
  int miscompares = 0;
  int err_pulses = 0;

  always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

  // keyboard model: held map, pending prefix bytes, expected FIFO contents
  logic [8:0] codes [8] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h02D, 9'h029, 9'h076, 9'h05A};
  logic [7:0] m_held;
  logic       m_ovf;
  logic [7:0] m_scan;
  int         m_errs = 0;
  logic [7:0] pfx[$];
  logic [4:0] exp_q[$];
  logic [4:0] got_q[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    m_held = 8'h00; m_ovf = 1'b0; m_scan = 8'h00;
    pfx.delete(); exp_q.delete();
  endtask

  function automatic int lookup(input logic ext, input logic [7:0] b);
    for (int i = 0; i < 8; i++) if (codes[i] == {ext, b}) return i;
    return -1;
  endfunction

  task automatic push_exp(input logic [4:0] e);
    if (exp_q.size() < 4) exp_q.push_back(e);
    else m_ovf = 1'b1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int k;
    logic ext, brk;
    m_scan = b;
    if (b == 8'hE0 || b == 8'hF0) begin
      pfx.push_back(b);
      if (!(pfx.size() == 1 || (pfx.size() == 2 && pfx[0] == 8'hE0 && pfx[1] == 8'hF0)))
        pfx.delete();
    end else begin
      ext = 1'b0; brk = 1'b0;
      foreach (pfx[j]) begin
        if (pfx[j] == 8'hE0) ext = 1'b1;
        if (pfx[j] == 8'hF0) brk = 1'b1;
      end
      pfx.delete();
      k = lookup(ext, b);
      if (k >= 0) begin
        if (!brk && !m_held[k]) begin
          m_held[k] = 1'b1; push_exp({1'b0, 4'(k)});
        end else if (brk && m_held[k]) begin
          m_held[k] = 1'b0; push_exp({1'b1, 4'(k)});
        end
      end
    end
  endtask

  task automatic model_err();
    pfx.delete();
    m_errs++;
  endtask

  // nbits < 11 sends a truncated frame
  task automatic send_frame(input logic [7:0] b, input bit flip_par, input int nbits, input int hp);
    logic [10:0] fb;
    fb = {1'b1, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2data = fb[i];
      tick(hp);
      ps2clk = 1'b0;
      tick(hp);
      ps2clk = 1'b1;
    end
    tick(hp / 2);
    ps2data = 1'b1;
    tick(40);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 25);
    model_byte(b);
  endtask

  task automatic drain();
    got_q.delete();
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (ev_valid !== 1'b1) break;
      got_q.push_back({ev_release, ev_key});
      ev_ready = 1'b1;
      @(posedge clk); #1;
      ev_ready = 1'b0;
    end
  endtask

  task automatic release_all();
    for (int k = 0; k < 8; k++) begin
      if (m_held[k]) begin
        if (codes[k][8]) send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(codes[k][7:0]);
      end
    end
    drain();
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL release_all_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; ps2clk = 1'b1; ps2data = 1'b1; ev_ready = 1'b0;
    tick(5);
    rst = 1'b0;
    m_reset();
    @(negedge clk);
    vectors++;
    if (key_held !== 8'h00 || ev_valid !== 1'b0 || ev_release !== 1'b0 || ev_key !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_events: held=%h valid=%b rel=%b key=%0d want all 0", key_held, ev_valid, ev_release, ev_key);
    end
    vectors++;
    if (scancode !== 8'h00 || frame_err !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status: scan=%h err=%b ovf=%b want 0", scancode, frame_err, overflow);
    end
  endtask

  task automatic test_up_make();
    send_byte(8'hE0);
    send_byte(8'h75);
    @(negedge clk);
    vectors++;
    if (key_held !== 8'h01) begin
      miscompares++; $display("FAIL up_make_held: got %h want %h", key_held, 8'h01);
    end
    vectors++;
    if (ev_valid !== 1'b1 || scancode !== 8'h75) begin
      miscompares++; $display("FAIL up_make_head: valid=%b scan=%h want 1 75", ev_valid, scancode);
    end
    drain();
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== 5'b0_0000) begin
      miscompares++; $display("FAIL up_make_event: got %0d events first=%h want 1 event 00", got_q.size(), got_q.size() ? got_q[0] : 5'h1F);
    end
    exp_q.delete();
  endtask

  task automatic test_release_repeat();
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    @(negedge clk);
    vectors++;
    if (key_held !== 8'h00) begin
      miscompares++; $display("FAIL up_break_held: got %h want 00", key_held);
    end
    for (int r = 0; r < 3; r++) begin
      send_byte(8'hE0); send_byte(8'h75);
    end
    drain();
    vectors++;
    if (got_q.size() != exp_q.size() || got_q.size() != 2) begin
      miscompares++; $display("FAIL release_repeat_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL release_repeat_ev%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_unmapped();
    release_all();
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    @(negedge clk);
    vectors++;
    if (scancode !== 8'h1C || key_held !== 8'h00 || ev_valid !== 1'b0) begin
      miscompares++; $display("FAIL unmapped: scan=%h held=%h valid=%b want 1c 00 0", scancode, key_held, ev_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_parity_err();
    send_frame(8'h29, 1'b1, 11, 25);
    model_err();
    @(negedge clk);
    vectors++;
    if (err_pulses != m_errs) begin
      miscompares++; $display("FAIL parity_err_pulse: got %0d want %0d", err_pulses, m_errs);
    end
    vectors++;
    if (ev_valid !== 1'b0 || key_held !== m_held || scancode !== m_scan) begin
      miscompares++; $display("FAIL parity_err_state: valid=%b held=%h scan=%h want 0 %h %h", ev_valid, key_held, scancode, m_held, m_scan);
    end
    send_byte(8'h29);
    @(negedge clk);
    vectors++;
    if (key_held[5] !== 1'b1) begin
      miscompares++; $display("FAIL parity_recover_held: got %b want 1", key_held[5]);
    end
    drain();
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== 5'b0_0101) begin
      miscompares++; $display("FAIL parity_recover_ev: got %0d events want one 05", got_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_overflow();
    release_all();
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'h72);
    send_byte(8'hE0); send_byte(8'h6B);
    send_byte(8'hE0); send_byte(8'h74);
    send_byte(8'h2D);
    @(negedge clk);
    vectors++;
    if (key_held !== 8'h1F || key_held !== m_held) begin
      miscompares++; $display("FAIL overflow_held: got %h want %h", key_held, m_held);
    end
    vectors++;
    if (overflow !== 1'b1 || overflow !== m_ovf) begin
      miscompares++; $display("FAIL overflow_flag: got %b want %b", overflow, m_ovf);
    end
    drain();
    vectors++;
    if (got_q.size() != exp_q.size() || got_q.size() != 4) begin
      miscompares++; $display("FAIL overflow_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL overflow_ev%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_timeout();
    send_frame(8'h76, 1'b0, 4, 25);
    tick(TO / 2);
    vectors++;
    if (err_pulses != m_errs) begin
      miscompares++; $display("FAIL timeout_early: got %0d want %0d", err_pulses, m_errs);
    end
    tick(TO);
    model_err();
    vectors++;
    if (err_pulses != m_errs) begin
      miscompares++; $display("FAIL timeout_pulse: got %0d want %0d", err_pulses, m_errs);
    end
    send_byte(8'h76);
    @(negedge clk);
    vectors++;
    if (key_held[6] !== 1'b1 || scancode !== 8'h76) begin
      miscompares++; $display("FAIL timeout_recover: held6=%b scan=%h want 1 76", key_held[6], scancode);
    end
    drain();
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== 5'b0_0110) begin
      miscompares++; $display("FAIL timeout_recover_ev: got %0d events want one 06", got_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h5A, 1'b0, 5, 25);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    m_reset();
    @(negedge clk);
    vectors++;
    if (key_held !== 8'h00 || overflow !== 1'b0 || ev_valid !== 1'b0 || err_pulses != m_errs) begin
      miscompares++;
      $display("FAIL midframe_reset: held=%h ovf=%b valid=%b errs=%0d want 00 0 0 %0d", key_held, overflow, ev_valid, err_pulses, m_errs);
    end
    send_byte(8'h5A);
    drain();
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== 5'b0_0111) begin
      miscompares++; $display("FAIL midframe_next_ev: got %0d events want one 07", got_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] pool [12] = '{8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h2D, 8'h29, 8'h76, 8'h1C};
    logic [7:0] b;
    for (int n = 0; n < 48; n++) begin
      b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
      if ($urandom_range(0, 9) == 0) begin
        send_frame(b, 1'b1, 11, $urandom_range(18, 30));
        model_err();
      end else begin
        send_frame(b, 1'b0, 11, $urandom_range(18, 30));
        model_byte(b);
      end
      @(negedge clk);
      vectors++;
      if (key_held !== m_held || scancode !== m_scan || err_pulses != m_errs) begin
        miscompares++;
        $display("FAIL rand_state%0d: held=%h scan=%h errs=%0d want %h %h %0d", n, key_held, scancode, err_pulses, m_held, m_scan, m_errs);
      end
      if (n % 6 == 5) begin
        drain();
        vectors++;
        if (got_q.size() != exp_q.size()) begin
          miscompares++; $display("FAIL rand_count%0d: got %0d want %0d", n, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
          vectors++;
          if (got_q[i] !== exp_q[i]) begin
            miscompares++; $display("FAIL rand_ev%0d_%0d: got %h want %h", n, i, got_q[i], exp_q[i]);
          end
        end
        exp_q.delete();
      end
    end
    vectors++;
    if (overflow !== m_ovf) begin
      miscompares++; $display("FAIL rand_overflow: got %b want %b", overflow, m_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_up_make();
    test_release_repeat();
    test_unmapped();
    test_parity_err();
    test_overflow();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
